hack_uart_rx: RTL and testbench

HACK_UART_RX -- requirements
Module: hack_uart_rx

---
 rtl/hack_uart_rx.sv | 174 +++++++++++++++++
 tb/tb_hack_uart_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hack_uart_rx.sv
// 8N1 serial receiver with a small byte FIFO, presenting the head byte as a
// zero-extended 16-bit Hack word plus sticky overrun / framing-error flags.
module hack_uart_rx #(
  parameter int BAUD  = 104,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd,
  input  logic        err_clr,
  output logic [15:0] data_out,
  output logic        empty,
  output logic        full,
  output logic        busy,
  output logic        overrun,
  output logic        frame_err
);

  localparam int DATA_W = 8;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [15:0] CNT_HALF = 16'(BAUD / 2 - 1);
  localparam logic [15:0] CNT_FULL = 16'(BAUD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PUSH,
    WAIT_HIGH
  } state_t;

  state_t              state, state_nxt;
  logic [15:0]         cnt, cnt_nxt;
  logic [2:0]          bit_cnt, bit_nxt;
  logic [DATA_W-1:0]   shreg, sh_nxt;
  logic                push_req, ferr_set, expired;

  logic                rx_p0, rx_s, rx_prev;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                wr_en, pop, ovr_set;

  // Stage p0/p1: two-flop synchronizer, plus one delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_s    <= rx_p0;
      rx_prev <= rx_s;
    end
  end

  assign expired = (cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_cnt <= 3'd0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nxt = START;
          cnt_nxt   = CNT_HALF;
        end
      end
      START: begin
        if (!expired) begin
          cnt_nxt = cnt - 16'd1;
        end else if (!rx_s) begin
          state_nxt = DATA;
          cnt_nxt   = CNT_FULL;
          bit_nxt   = 3'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!expired) begin
          cnt_nxt = cnt - 16'd1;
        end else begin
          // LSB-first: each new bit enters at the top and walks down to bit 0
          sh_nxt  = {rx_s, shreg[DATA_W-1:1]};
          cnt_nxt = CNT_FULL;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (!expired) begin
          cnt_nxt = cnt - 16'd1;
        end else if (rx_s) begin
          state_nxt = PUSH;
        end else begin
          ferr_set  = 1'b1;
          state_nxt = WAIT_HIGH;
        end
      end
      PUSH: begin
        push_req  = 1'b1;
        state_nxt = IDLE;
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push at full still lands
  assign wr_en   = push_req && (!full || rd);
  assign ovr_set = push_req && full && !rd;
  assign pop     = rd && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set  | (overrun   & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

  assign empty    = (count == CW'(0));
  assign full     = (count == CW'(DEPTH));
  assign busy     = (state != IDLE);
  assign data_out = empty ? 16'h0000 : {8'h00, mem[rd_ptr]};

endmodule

// File: tb/tb_hack_uart_rx.sv
// Directed bench for hack_uart_rx at BAUD=4, DEPTH=4: serial frames are driven
// bit by bit and the FIFO/flag outputs are checked with immediate assertions.
module tb_hack_uart_rx;

  localparam int BAUD   = 4;
  localparam int DEPTH  = 4;
  localparam int GLITCH = (BAUD / 2 - 2 > 0) ? BAUD / 2 - 2 : 1;

  logic        clk = 1'b0;
  logic        rst, rx, rd, err_clr;
  logic [15:0] data_out;
  logic        empty, full, busy, overrun, frame_err;

  int checks = 0;
  int errors = 0;

  hack_uart_rx #(.BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd       (rd),
    .err_clr  (err_clr),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .busy     (busy),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    hold(1'b0, BAUD);
    for (int i = 0; i < 8; i++) hold(b[i], BAUD);
    hold(1'b1, BAUD);
  endtask

  task automatic pop_one();
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] b7e;
    rst = 1'b1; rx = 1'b1; rd = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data_out, 16'h0000);
    check("rst_empty", {15'd0, empty}, 16'd1);
    check("rst_full", {15'd0, full}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ovr", {15'd0, overrun}, 16'd0);
    check("rst_ferr", {15'd0, frame_err}, 16'd0);
    rst = 1'b0;
    hold(1'b1, 4);

    // single byte then pop
    send_byte(8'h31);
    hold(1'b1, 3);
    check("one_data", data_out, 16'h0031);
    check("one_empty", {15'd0, empty}, 16'd0);
    pop_one();
    check("one_pop_data", data_out, 16'h0000);
    check("one_pop_empty", {15'd0, empty}, 16'd1);

    // back-to-back frames
    send_byte(8'h31);
    send_byte(8'h0A);
    send_byte(8'h30);
    hold(1'b1, 3);
    check("b2b_0", data_out, 16'h0031);
    pop_one();
    check("b2b_1", data_out, 16'h000A);
    pop_one();
    check("b2b_2", data_out, 16'h0030);
    pop_one();
    check("b2b_end", data_out, 16'h0000);
    check("b2b_empty", {15'd0, empty}, 16'd1);

    // fill to DEPTH, then overrun
    for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i));
    hold(1'b1, 3);
    check("fill_full", {15'd0, full}, 16'd1);
    check("fill_ovr0", {15'd0, overrun}, 16'd0);
    send_byte(8'h45);
    hold(1'b1, 3);
    check("ovr_set", {15'd0, overrun}, 16'd1);
    check("ovr_full", {15'd0, full}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      check("ovr_pop", data_out, 16'h0041 + 16'(i));
      pop_one();
    end
    check("ovr_drain", {15'd0, empty}, 16'd1);
    check("ovr_sticky", {15'd0, overrun}, 16'd1);
    pulse_clr();
    check("ovr_clr", {15'd0, overrun}, 16'd0);

    // framing error with stop held low for 3 bit times
    hold(1'b0, BAUD);
    for (int i = 0; i < 8; i++) hold(i[0] ? 1'b0 : 1'b1, BAUD);
    hold(1'b0, 3 * BAUD);
    check("ferr_set", {15'd0, frame_err}, 16'd1);
    check("ferr_busy", {15'd0, busy}, 16'd1);
    check("ferr_empty", {15'd0, empty}, 16'd1);
    hold(1'b1, 8);
    check("ferr_idle", {15'd0, busy}, 16'd0);
    send_byte(8'h04);
    hold(1'b1, 3);
    check("ferr_next", data_out, 16'h0004);
    pop_one();
    pulse_clr();
    check("ferr_clr", {15'd0, frame_err}, 16'd0);

    // short low glitch
    hold(1'b0, GLITCH);
    hold(1'b1, 10);
    check("gl_busy", {15'd0, busy}, 16'd0);
    check("gl_empty", {15'd0, empty}, 16'd1);
    check("gl_flags", {14'd0, overrun, frame_err}, 16'd0);

    // reset during bit 4 of 0x7E
    b7e = 8'h7E;
    hold(1'b0, BAUD);
    for (int i = 0; i < 4; i++) hold(b7e[i], BAUD);
    hold(b7e[4], 2);
    rst = 1'b1;
    hold(1'b1, 2);
    rst = 1'b0;
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_empty", {15'd0, empty}, 16'd1);
    hold(1'b1, 8);
    send_byte(8'h31);
    hold(1'b1, 3);
    check("mid_rst_data", data_out, 16'h0031);
    check("mid_rst_flags", {14'd0, overrun, frame_err}, 16'd0);
    pop_one();
    check("mid_rst_only", {15'd0, empty}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
